// File: rtl/pixel_pkg.sv
// Shared definitions for the frame-buffer pixel streamer.
// Holds the FSM encoding, default geometry and a small sizing helper.
package pixel_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_EMIT  = 2'd3;

    localparam int PIX_W_DEF        = 24;
    localparam int PIX_PER_WORD_DEF = 2;
    localparam int MAX_ADDR_DEF     = 64800;

    // Width of a slot index; a one-slot word still gets a 1-bit counter.
    function automatic int slot_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pixel_word_shifter.sv
// Word buffer that hands out packed pixels MSB slot first.
// Each accepted pixel shifts the word left by one pixel width.
module pixel_word_shifter
    import pixel_pkg::*;
#(
    parameter int PIX_W        = PIX_W_DEF,
    parameter int PIX_PER_WORD = PIX_PER_WORD_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clear,
    input  logic                          load,
    input  logic                          shift,
    input  logic [PIX_W*PIX_PER_WORD-1:0] word,
    output logic [PIX_W-1:0]              pix,
    output logic                          last
);

    localparam int WORD_W = PIX_W * PIX_PER_WORD;
    localparam int SLOT_W = slot_bits(PIX_PER_WORD);

    logic [WORD_W-1:0] word_q;
    logic [SLOT_W-1:0] slot;

    // Load a fresh word, or move the next slot into the top position.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            word_q <= '0;
            slot   <= '0;
        end else if (load) begin
            word_q <= word;
            slot   <= '0;
        end else if (shift) begin
            word_q <= word_q << PIX_W;
            slot   <= slot + 1'b1;
        end
    end

    assign pix  = word_q[WORD_W-1 -: PIX_W];
    assign last = (slot == SLOT_W'(PIX_PER_WORD - 1));

endmodule

// File: rtl/pixel_streamer.sv
// Frame-buffer reader: fetches packed words from synchronous memory
// and streams one pixel per valid/ready handshake.
module pixel_streamer
    import pixel_pkg::*;
#(
    parameter int PIX_W        = PIX_W_DEF,
    parameter int PIX_PER_WORD = PIX_PER_WORD_DEF,
    parameter int ADDR_W       = 16,
    parameter int MAX_ADDR     = MAX_ADDR_DEF,
    parameter int MEM_LAT      = 1,
    parameter int CONTINUOUS   = 0
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic                          FRAME_START,
    input  logic [PIX_W*PIX_PER_WORD-1:0] DATA_IN,
    output logic [ADDR_W-1:0]             MEM_ADDR,
    output logic                          MEM_RD,
    output logic [PIX_W-1:0]              PIX_DATA,
    output logic                          PIX_VALID,
    input  logic                          PIX_READY,
    output logic                          FRAME_END,
    output logic                          BUSY
);

    localparam int CNT_W = $clog2(MEM_LAT + 1);

    if (MAX_ADDR > (64'd1 << ADDR_W)) begin : g_addr_check
        $error("pixel_streamer: MAX_ADDR does not fit in ADDR_W");
    end
    if (MEM_LAT < 1 || PIX_PER_WORD < 1) begin : g_param_check
        $error("pixel_streamer: MEM_LAT and PIX_PER_WORD must be >= 1");
    end

    logic [1:0]       state;
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0] cnt;
    logic             cnt_done;
    logic             accept;
    logic             at_end;
    logic             last;
    logic [PIX_W-1:0] pix;

    assign cnt_done = (cnt == CNT_W'(1));
    assign accept   = (state == ST_EMIT) && PIX_READY;
    assign at_end   = (addr == ADDR_W'(MAX_ADDR - 1));

    // Frame sequencing: fetch, wait out memory latency, emit slots.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= ST_IDLE;
            addr  <= '0;
            cnt   <= '0;
        end else if (FRAME_START) begin
            state <= ST_FETCH;
            addr  <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state <= ST_IDLE;
                end
                ST_FETCH: begin
                    state <= ST_WAIT;
                    cnt   <= CNT_W'(MEM_LAT);
                end
                ST_WAIT: begin
                    if (cnt_done) state <= ST_EMIT;
                    else          cnt   <= cnt - 1'b1;
                end
                ST_EMIT: begin
                    if (accept && last) begin
                        if (at_end) begin
                            addr  <= '0;
                            state <= (CONTINUOUS != 0) ? ST_FETCH : ST_IDLE;
                        end else begin
                            addr  <= addr + 1'b1;
                            state <= ST_FETCH;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    pixel_word_shifter #(
        .PIX_W        (PIX_W),
        .PIX_PER_WORD (PIX_PER_WORD)
    ) u_shifter (
        .clk   (CLK),
        .reset (RESET),
        .clear (FRAME_START),
        .load  ((state == ST_WAIT) && cnt_done && !FRAME_START),
        .shift (accept && !last),
        .word  (DATA_IN),
        .pix   (pix),
        .last  (last)
    );

    assign MEM_ADDR  = addr;
    assign MEM_RD    = (state == ST_FETCH);
    assign PIX_VALID = (state == ST_EMIT);
    assign PIX_DATA  = PIX_VALID ? pix : '0;
    assign BUSY      = (state != ST_IDLE);
    assign FRAME_END = accept && last && at_end && !FRAME_START && !RESET;

endmodule

// File: tb/tb_pixel_streamer.sv
// Bench for pixel_streamer: three configurations against a frame model.
// Expected pixels come from memory contents in slot order.
module tb_pixel_streamer;

    localparam int LAT  [3] = '{1, 3, 2};
    localparam int MAXA [3] = '{4, 4, 3};

    logic        clk = 1'b0;
    logic        rst [3];
    logic        fs  [3];
    logic        rdy [3];
    logic [47:0] din [3];
    logic [15:0] maddr [3];
    logic        mrd [3];
    logic [23:0] pd  [3];
    logic        pv  [3];
    logic        fe  [3];
    logic        busy [3];

    logic [47:0] mem  [3][4];
    logic [47:0] line [3][3];
    logic        ctl_q [3];

    logic [23:0] got  [3][256];
    int          rda  [3][256];
    int          fe_pos [3][64];
    int ngot [3] = '{0, 0, 0};
    int nrd  [3] = '{0, 0, 0};
    int nfe  [3] = '{0, 0, 0};
    int stall_err [3] = '{0, 0, 0};
    int zero_err  [3] = '{0, 0, 0};
    int fe_err    [3] = '{0, 0, 0};
    logic        prev_v [3];
    logic        prev_r [3];
    logic [23:0] prev_d [3];
    logic [15:0] prev_a [3];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pixel_streamer #(.PIX_W(24), .PIX_PER_WORD(2), .ADDR_W(16),
        .MAX_ADDR(4), .MEM_LAT(1), .CONTINUOUS(0)) u_a (
        .CLK(clk), .RESET(rst[0]), .FRAME_START(fs[0]), .DATA_IN(din[0]),
        .MEM_ADDR(maddr[0]), .MEM_RD(mrd[0]), .PIX_DATA(pd[0]),
        .PIX_VALID(pv[0]), .PIX_READY(rdy[0]), .FRAME_END(fe[0]),
        .BUSY(busy[0]));

    pixel_streamer #(.PIX_W(24), .PIX_PER_WORD(2), .ADDR_W(16),
        .MAX_ADDR(4), .MEM_LAT(3), .CONTINUOUS(0)) u_b (
        .CLK(clk), .RESET(rst[1]), .FRAME_START(fs[1]), .DATA_IN(din[1]),
        .MEM_ADDR(maddr[1]), .MEM_RD(mrd[1]), .PIX_DATA(pd[1]),
        .PIX_VALID(pv[1]), .PIX_READY(rdy[1]), .FRAME_END(fe[1]),
        .BUSY(busy[1]));

    pixel_streamer #(.PIX_W(24), .PIX_PER_WORD(2), .ADDR_W(16),
        .MAX_ADDR(3), .MEM_LAT(2), .CONTINUOUS(1)) u_c (
        .CLK(clk), .RESET(rst[2]), .FRAME_START(fs[2]), .DATA_IN(din[2]),
        .MEM_ADDR(maddr[2]), .MEM_RD(mrd[2]), .PIX_DATA(pd[2]),
        .PIX_VALID(pv[2]), .PIX_READY(rdy[2]), .FRAME_END(fe[2]),
        .BUSY(busy[2]));

    // Synchronous memory: data appears LAT cycles after the read strobe.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            line[i][0] <= mrd[i] ? mem[i][maddr[i][1:0]]
                                 : 48'({$urandom, $urandom});
            line[i][1] <= line[i][0];
            line[i][2] <= line[i][1];
            ctl_q[i]   <= rst[i] | fs[i];
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++) din[i] = line[i][LAT[i]-1];
    end

    // Record reads, accepted pixels and frame ends; flag protocol slips.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (mrd[i] && nrd[i] < 256) begin
                rda[i][nrd[i]] = int'(maddr[i]);
                nrd[i]++;
            end
            if (pv[i] && rdy[i] && ngot[i] < 256) begin
                got[i][ngot[i]] = pd[i];
                ngot[i]++;
            end
            if (fe[i]) begin
                if (!(pv[i] && rdy[i])) fe_err[i]++;
                if (nfe[i] < 64) fe_pos[i][nfe[i]] = ngot[i];
                nfe[i]++;
            end
            if (!pv[i] && pd[i] != 24'd0) zero_err[i]++;
            if (prev_v[i] === 1'b1 && prev_r[i] === 1'b0 && !ctl_q[i]) begin
                if (!pv[i] || pd[i] != prev_d[i] || maddr[i] != prev_a[i])
                    stall_err[i]++;
            end
            prev_v[i] = pv[i];
            prev_r[i] = rdy[i];
            prev_d[i] = pd[i];
            prev_a[i] = maddr[i];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] pix_exp(input int i, input int k);
        logic [47:0] w;
        w = mem[i][(k / 2) % MAXA[i]];
        return (k % 2 == 0) ? w[47:24] : w[23:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input int i);
        tick();
        fs[i] = 1'b1;
        tick();
        fs[i] = 1'b0;
    endtask

    task automatic chk_zero(input int i, input string tag);
        @(negedge clk);
        chk({tag, "_addr"}, maddr[i], 0);
        chk({tag, "_rd"},   mrd[i],   0);
        chk({tag, "_data"}, pd[i],    0);
        chk({tag, "_valid"}, pv[i],   0);
        chk({tag, "_fend"}, fe[i],    0);
        chk({tag, "_busy"}, busy[i],  0);
    endtask

    task automatic measure_lat(input int i, input string tag, input int exp);
        int lat;
        lat = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            lat++;
            if (pv[i]) break;
        end
        chk(tag, lat, exp);
    endtask

    task automatic wait_idle(input int i, input bit rnd, input string tag);
        bit done;
        done = 1'b0;
        for (int c = 0; c < 3000 && !done; c++) begin
            tick();
            if (rnd) rdy[i] = ($urandom % 3) != 0;
            @(negedge clk);
            if (!busy[i]) done = 1'b1;
        end
        chk({tag, "_timeout"}, done, 1'b1);
        chk({tag, "_idle_valid"}, pv[i], 0);
    endtask

    task automatic check_frame(input int i, input string tag, input int g0,
                               input int r0, input int f0);
        int n;
        n = 2 * MAXA[i];
        chk({tag, "_npix"}, ngot[i] - g0, n);
        for (int k = 0; k < n; k++)
            chk($sformatf("%s_pix%0d", tag, k), got[i][g0+k], pix_exp(i, k));
        chk({tag, "_nrd"}, nrd[i] - r0, MAXA[i]);
        for (int a = 0; a < MAXA[i]; a++)
            chk($sformatf("%s_rd%0d", tag, a), rda[i][r0+a], a);
        chk({tag, "_nfe"}, nfe[i] - f0, 1);
        chk({tag, "_fepos"}, fe_pos[i][f0], g0 + n);
    endtask

    initial begin
        int g0, r0, f0, fpre;
        bit hit;
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1;
            fs[i]  = 1'b0;
            rdy[i] = 1'b0;
            for (int a = 0; a < 4; a++) mem[i][a] = 48'({$urandom, $urandom});
        end
        repeat (3) tick();

        chk_zero(0, "A_reset");
        tick();
        rst[0] = 1'b0;
        rdy[0] = 1'b1;
        g0 = ngot[0]; r0 = nrd[0]; f0 = nfe[0];
        start(0);
        measure_lat(0, "A_latency", 3);
        wait_idle(0, 1'b0, "A_frame");
        check_frame(0, "A_frame", g0, r0, f0);

        g0 = ngot[0]; r0 = nrd[0]; f0 = nfe[0];
        start(0);
        wait_idle(0, 1'b1, "A_rand");
        check_frame(0, "A_rand", g0, r0, f0);

        fpre = nfe[0];
        start(0);
        hit = 1'b0;
        for (int c = 0; c < 500 && !hit; c++) begin
            rdy[0] = $urandom % 2;
            @(negedge clk);
            if (pv[0] && maddr[0] == 16'd2) hit = 1'b1;
            else tick();
        end
        chk("R_reach_addr2", hit, 1'b1);
        fs[0] = 1'b1;
        tick();
        fs[0] = 1'b0;
        g0 = ngot[0]; r0 = nrd[0]; f0 = nfe[0];
        chk("R_no_fend", nfe[0] - fpre, 0);
        @(negedge clk);
        chk("R_valid_drop", pv[0], 0);
        chk("R_busy", busy[0], 1);
        chk("R_addr0", maddr[0], 0);
        wait_idle(0, 1'b1, "R_frame");
        check_frame(0, "R_frame", g0, r0, f0);

        tick();
        rdy[0] = 1'b0;
        start(0);
        hit = 1'b0;
        for (int c = 0; c < 50 && !hit; c++) begin
            @(negedge clk);
            if (pv[0]) hit = 1'b1;
        end
        chk("X_emit_reached", hit, 1'b1);
        rst[0] = 1'b1;
        tick();
        rst[0] = 1'b0;
        chk_zero(0, "X_reset");
        repeat (4) tick();
        @(negedge clk);
        chk("X_stay_idle", busy[0], 0);
        rdy[0] = 1'b1;
        g0 = ngot[0]; r0 = nrd[0]; f0 = nfe[0];
        start(0);
        wait_idle(0, 1'b0, "X_frame");
        check_frame(0, "X_frame", g0, r0, f0);

        chk_zero(1, "B_reset");
        tick();
        rst[1] = 1'b0;
        rdy[1] = 1'b1;
        g0 = ngot[1]; r0 = nrd[1]; f0 = nfe[1];
        start(1);
        measure_lat(1, "B_latency", 5);
        wait_idle(1, 1'b1, "B_frame");
        check_frame(1, "B_frame", g0, r0, f0);

        tick();
        rst[2] = 1'b0;
        g0 = ngot[2]; r0 = nrd[2]; f0 = nfe[2];
        start(2);
        hit = 1'b0;
        for (int c = 0; c < 1000 && !hit; c++) begin
            tick();
            rdy[2] = $urandom % 2;
            @(negedge clk);
            if (ngot[2] - g0 >= 8) hit = 1'b1;
        end
        chk("C_timeout", hit, 1'b1);
        chk("C_nfe", nfe[2] - f0, 1);
        chk("C_fepos", fe_pos[2][f0], g0 + 6);
        for (int a = 0; a < 4; a++)
            chk($sformatf("C_rd%0d", a), rda[2][r0+a], a % 3);
        for (int k = 0; k < 8; k++)
            chk($sformatf("C_pix%0d", k), got[2][g0+k], pix_exp(2, k));
        chk("C_busy", busy[2], 1);
        tick();
        rst[2] = 1'b1;
        tick();

        for (int i = 0; i < 3; i++) begin
            chk($sformatf("stall_hold%0d", i), stall_err[i], 0);
            chk($sformatf("data_zero%0d", i), zero_err[i], 0);
            chk($sformatf("fend_accept%0d", i), fe_err[i], 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
